// File: rtl/sb_pkg.sv
// Shared types and constants for the register scoreboard.
// A latency of all-ones means the producer is only known complete at writeback.
package sb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int LAT_W_DEF  = 3;
    localparam int TAG_W_DEF  = 3;

    localparam logic [LAT_W_DEF-1:0] LAT_UNKNOWN = '1;
    localparam logic [LAT_W_DEF-1:0] LAT_ALU     = 3'd0;
    localparam logic [LAT_W_DEF-1:0] LAT_LOAD    = 3'd1;
    localparam logic [LAT_W_DEF-1:0] LAT_MUL     = 3'd2;

    typedef struct packed {
        logic                 busy;
        logic [TAG_W_DEF-1:0] tag;
        logic [LAT_W_DEF-1:0] cnt;
    } entry_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: records the newest in-flight producer of a register
// and counts down until its result becomes forwardable.
module sb_entry
    import sb_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             set_en,
    input  logic [TAG_W-1:0] set_tag,
    input  logic [LAT_W-1:0] set_lat,
    input  logic             wb_sel,
    input  logic [TAG_W-1:0] wb_tag,
    output logic             busy,
    output logic [TAG_W-1:0] tag,
    output logic [LAT_W-1:0] cnt
);

    localparam logic [LAT_W-1:0] LAT_UNK = '1;

    // A new issue always takes ownership, so a same-cycle writeback of the
    // previous producer cannot clear the freshly set entry.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            busy <= 1'b0;
            tag  <= '0;
            cnt  <= '0;
        end else if (set_en) begin
            busy <= 1'b1;
            tag  <= set_tag;
            cnt  <= set_lat;
        end else begin
            if (wb_sel && busy && (wb_tag == tag)) begin
                busy <= 1'b0;
            end
            if (busy && (cnt != '0) && (cnt != LAT_UNK)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write tracking with
// per-operand stall/forward decisions and a wrapping producer tag counter.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RD_PORTS = 2,
    parameter int LAT_W    = LAT_W_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       issue_valid,
    input  logic                       issue_we,
    input  logic [ADDR_W-1:0]          issue_waddr,
    input  logic [LAT_W-1:0]           issue_lat,
    output logic [TAG_W-1:0]           issue_tag,
    input  logic                       wb_valid,
    input  logic [ADDR_W-1:0]          wb_waddr,
    input  logic [TAG_W-1:0]           wb_tag,
    input  logic [RD_PORTS-1:0]        src_valid,
    input  logic [RD_PORTS*ADDR_W-1:0] src_addr,
    output logic [RD_PORTS-1:0]        src_busy,
    output logic [RD_PORTS-1:0]        src_ready,
    output logic                       stall,
    output logic [(1<<ADDR_W)-1:0]     busy_vec
);

    localparam int NREG = 1 << ADDR_W;

    logic [TAG_W-1:0] seq;
    logic [TAG_W-1:0] tag_arr [NREG];
    logic [LAT_W-1:0] cnt_arr [NREG];
    logic             issue_wr;

    assign issue_wr  = issue_valid && issue_we;
    assign issue_tag = seq;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            seq <= '0;
        end else if (issue_valid) begin
            seq <= seq + 1'b1;
        end
    end

    // Register 0 is hardwired zero and can never have a pending write.
    assign busy_vec[0] = 1'b0;
    assign tag_arr[0]  = '0;
    assign cnt_arr[0]  = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);

        sb_entry #(
            .TAG_W (TAG_W),
            .LAT_W (LAT_W)
        ) u_entry (
            .clk     (clk),
            .resetn  (resetn),
            .flush   (flush),
            .set_en  (issue_wr && (issue_waddr == IDX)),
            .set_tag (seq),
            .set_lat (issue_lat),
            .wb_sel  (wb_valid && (wb_waddr == IDX)),
            .wb_tag  (wb_tag),
            .busy    (busy_vec[i]),
            .tag     (tag_arr[i]),
            .cnt     (cnt_arr[i])
        );
    end

    // An operand is obtainable when idle, when its countdown has expired, or
    // when its owning producer is writing back this very cycle.
    logic [ADDR_W-1:0] addr;

    always_comb begin
        src_busy  = '0;
        src_ready = '0;
        stall     = 1'b0;
        addr      = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            addr         = src_addr[p*ADDR_W +: ADDR_W];
            src_busy[p]  = busy_vec[addr];
            src_ready[p] = !busy_vec[addr] || (cnt_arr[addr] == '0) ||
                           (wb_valid && (wb_waddr == addr) && (wb_tag == tag_arr[addr]));
            if (src_valid[p] && !src_ready[p]) begin
                stall = 1'b1;
            end
        end
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register scoreboard for the decode stage. It replaces fixed per-stage address-compare hazard logic with per-register pending-write tracking. Each entry records the in-flight producer's tag and a countdown to when its result can be forwarded. Decode uses it to decide, per source operand, stall versus forward, including long- and indeterminate-latency producers (mul/div) and repeated writes to the same register.

## Interface
Parameters:
- ADDR_W, 5, register address width; 2^ADDR_W entries, entry 0 never busy
- RD_PORTS, 2, number of source-operand lookup ports
- LAT_W, 3, latency counter width; all-ones = LAT_UNKNOWN (wait for writeback)
- TAG_W, 3, producer tag width; 2^TAG_W must exceed max in-flight writes

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of all entries (exception/ertn)
- issue_valid  in  1  instruction leaves decode this cycle (to_exe_valid & exe_allowin)
- issue_we  in  1  issuing instruction writes a register
- issue_waddr  in  ADDR_W  destination register
- issue_lat  in  LAT_W  cycles after issue+1 until result is forwardable
- issue_tag  out  TAG_W  tag assigned to the issuing instruction (current sequence counter)
- wb_valid  in  1  register-file write this cycle
- wb_waddr  in  ADDR_W  writeback register
- wb_tag  in  TAG_W  tag of writing instruction
- src_valid  in  RD_PORTS  port p carries a real source operand
- src_addr  in  RD_PORTS*ADDR_W  port p address at bits [p*ADDR_W +: ADDR_W]
- src_busy  out  RD_PORTS  pending write to src_addr[p]
- src_ready  out  RD_PORTS  operand obtainable (not busy, forwardable, or matching wb this cycle)
- stall  out  1  OR over p of src_valid[p] & ~src_ready[p]
- busy_vec  out  2^ADDR_W  per-register busy bits (debug/verification)

## Operation
- Entry state: busy, tag[TAG_W], cnt[LAT_W].
- Issue, when issue_valid & issue_we & issue_waddr≠0: entry[waddr] becomes busy=1, tag=issue_tag, cnt=issue_lat. Overwrites any existing entry (WAW: newest producer owns the register).
- Sequence counter increments on every issue_valid and wraps modulo 2^TAG_W.
- Countdown: each cycle, busy entries with cnt∉{0, LAT_UNKNOWN} decrement. cnt holds at 0. LAT_UNKNOWN never decrements.
- Writeback, when wb_valid & wb_waddr≠0 & entry busy & entry.tag==wb_tag: clear busy next cycle. A tag mismatch (stale write superseded by a newer issue) is ignored.
- Lookup is combinational over registered state.
  - src_busy[p] = entry[a].busy.
  - src_ready[p] = ~busy | cnt==0 | (wb_valid & wb_waddr==a & wb_tag==entry.tag).
  - Address 0 is always ready.
  - src_valid=0 does not affect stall.
- Simultaneous issue and writeback to the same register: issue wins; the entry holds the new producer.
- flush: clears all busy bits and resets the sequence counter to 0. Overrides a same-cycle issue.
- issue_valid while stall=1 is a protocol violation; the block still records the issue.

## Timing
- Reset: all entries cleared, counter 0. Outputs: stall=0, src_busy=0, src_ready=all 1, busy_vec=0, issue_tag=0.
- Issue at cycle t with lat L: busy visible at t+1; src_ready at t+1+L.
  - ALU, L=0: no bubble.
  - Load, L=1: one stall cycle.
- LAT_UNKNOWN: ready in the cycle of the matching wb (wb bypass); busy clear from the next cycle.
- flush/reset effective the following cycle. Outputs in the flush cycle reflect pre-flush state.
- No output depends combinationally on issue_* except issue_tag (registered counter value).

## Structure
- Shared package sb_pkg:
  - LAT_UNKNOWN
  - latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=2
  - entry struct {busy, tag, cnt}
- Sub-module sb_entry: one register entry with set/clear/decrement logic, generate-instantiated 2^ADDR_W−1 times (index 0 tied off).
- Lookup muxes and stall reduction live in the top.

## Test plan
- Reset, then issue r5 lat 0 → cycle t+1: busy_vec[5]=1, src_addr=5 gives src_busy=1, src_ready=1, stall=0.
- Issue r7 lat 1 (load), next instruction reads r7 → stall=1 for exactly one cycle, then src_ready=1.
- Issue r9 LAT_UNKNOWN tag 2; src r9 stalls until wb(r9, tag 2) → src_ready=1 that cycle; busy_vec[9]=0 next cycle.
- WAW: issue r4 tag 0 LAT_UNKNOWN, then r4 tag 1 LAT_UNKNOWN; wb(r4, tag 0) → r4 stays busy; wb(r4, tag 1) → clears.
- Same-cycle issue r3 (tag 5) and wb(r3, old tag) → r3 busy with tag 5. Source r0 with issue_waddr=0 → never busy, stall=0.
- flush with 4 busy entries plus a concurrent issue → next cycle busy_vec=0, issue_tag=0.
